// File: rtl/stim_gen_tx_if.sv
// Lane bus between the stimulus generator and the phy_tx loopback path.
// The master drives the transmit lanes and receives the looped-back lanes.
interface stim_gen_tx_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8
);
  logic [N_CH*DATA_W-1:0] data_out;
  logic [N_CH-1:0]        valid_out;
  logic [N_CH*DATA_W-1:0] data_back;
  logic [N_CH-1:0]        valid_back;

  modport master (
    output data_out,
    output valid_out,
    input  data_back,
    input  valid_back
  );

  modport slave (
    input  data_out,
    input  valid_out,
    output data_back,
    output valid_back
  );
endinterface

// File: rtl/stim_gen_tx.sv
// Burst stimulus generator for the phy_tx datapath.
// Drives N_CH lanes in bursts of BURST_LEN beats separated by GAP_LEN idle
// cycles, with fixed / counter / Galois-LFSR patterns (lane i = base + i).
// Optional loopback checker enabled by the macro STIM_GEN_TX_CHECKER_EN.
//
// state | meaning
// IDLE  | waiting for start, valid_out low
// BURST | one beat on the lanes every cycle
// GAP   | idle cycles between bursts, last beat held, base frozen
// DONE  | one-cycle done pulse, then back to IDLE
module stim_gen_tx #(
  parameter int                N_CH      = 4,
  parameter int                DATA_W    = 8,
  parameter int                BURST_LEN = 4,
  parameter int                GAP_LEN   = 2,
  parameter logic [DATA_W-1:0] SEED      = 'hCC,
  parameter logic [DATA_W-1:0] LFSR_TAPS = 'hB8
) (
  input  logic              clk_f,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [7:0]        n_bursts,
  stim_gen_tx_if.master     bus,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_count
);

  localparam int DW_ALL = N_CH * DATA_W;
  localparam int BCW    = (BURST_LEN < 2) ? 1 : $clog2(BURST_LEN);
  localparam int GCW    = (GAP_LEN < 2) ? 1 : $clog2(GAP_LEN);
  localparam logic [BCW-1:0] BEAT_LOAD = BCW'(BURST_LEN - 1);
  localparam logic [GCW-1:0] GAP_LOAD  = (GAP_LEN > 0) ? GCW'(GAP_LEN - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP, S_DONE} state_t;

  // Pattern step; mode 11 behaves like fixed.
  function automatic logic [DATA_W-1:0] advance(input logic [1:0] m,
                                                input logic [DATA_W-1:0] v);
    case (m)
      2'b01:   advance = v + DATA_W'(1);
      2'b10:   advance = (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
      default: advance = v;
    endcase
  endfunction

  // Lane i carries base + i, wrapping at DATA_W bits.
  function automatic logic [DW_ALL-1:0] spread(input logic [DATA_W-1:0] b);
    spread = '0;
    for (int i = 0; i < N_CH; i++) spread[i*DATA_W +: DATA_W] = b + DATA_W'(i);
  endfunction

  state_t              state_q;
  logic [1:0]          mode_q;
  logic [N_CH-1:0]     chen_q;
  logic [7:0]          nb_q;
  logic [7:0]          burst_q;
  logic [BCW-1:0]      beat_q;
  logic [GCW-1:0]      gap_q;
  logic [DATA_W-1:0]   base_q;
  logic [DW_ALL-1:0]   data_q;
  logic [N_CH-1:0]     valid_q;
  logic                busy_q;
  logic                done_q;

  logic [DATA_W-1:0]   start_base_d;
  logic [7:0]          burst_d;
  logic                start_go;
  logic                last_burst;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign start_base_d = (mode == 2'b10 && SEED == '0) ? DATA_W'(1) : SEED;
  assign start_go     = (state_q == S_IDLE) && start;
  assign burst_d      = burst_q + 8'd1;
  assign last_burst   = (nb_q != 8'd0) && (burst_d == nb_q);

  // Sequencer: base_q always holds the value for the next beat to emit.
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      chen_q  <= '0;
      nb_q    <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
      base_q  <= '0;
      data_q  <= '0;
      valid_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          valid_q <= '0;
          if (start) begin
            mode_q  <= mode;
            chen_q  <= ch_en;
            nb_q    <= n_bursts;
            burst_q <= '0;
            beat_q  <= BEAT_LOAD;
            data_q  <= spread(start_base_d);
            valid_q <= ch_en;
            base_q  <= advance(mode, start_base_d);
            busy_q  <= 1'b1;
            state_q <= S_BURST;
          end
        end
        S_BURST: begin
          if (stop) begin
            valid_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (beat_q == '0) begin
            burst_q <= burst_d;
            if (last_burst) begin
              valid_q <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (GAP_LEN == 0) begin
              data_q  <= spread(base_q);
              valid_q <= chen_q;
              base_q  <= advance(mode_q, base_q);
              beat_q  <= BEAT_LOAD;
            end else begin
              valid_q <= '0;
              gap_q   <= GAP_LOAD;
              state_q <= S_GAP;
            end
          end else begin
            data_q  <= spread(base_q);
            valid_q <= chen_q;
            base_q  <= advance(mode_q, base_q);
            beat_q  <= beat_q - BCW'(1);
          end
        end
        S_GAP: begin
          if (stop) begin
            valid_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (gap_q == '0) begin
            data_q  <= spread(base_q);
            valid_q <= chen_q;
            base_q  <= advance(mode_q, base_q);
            beat_q  <= BEAT_LOAD;
            state_q <= S_BURST;
          end else begin
            gap_q <= gap_q - GCW'(1);
          end
        end
        default: begin
          valid_q <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;

`ifdef STIM_GEN_TX_CHECKER_EN
  logic [DATA_W-1:0] exp_q [N_CH];
  logic [15:0]       err_q;
  logic [16:0]       mis_d;
  logic [16:0]       sum_d;

  // Number of lanes whose looped-back beat differs from its expected value.
  always_comb begin
    mis_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.valid_back[i] && (bus.data_back[i*DATA_W +: DATA_W] != exp_q[i]))
        mis_d = mis_d + 17'd1;
    end
  end

  assign sum_d = {1'b0, err_q} + mis_d;

  // Per-lane expected generators advance on their own valid_back, not on tx timing.
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) exp_q[i] <= '0;
      err_q <= '0;
    end else if (start_go) begin
      for (int i = 0; i < N_CH; i++) exp_q[i] <= start_base_d + DATA_W'(i);
      err_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (bus.valid_back[i]) exp_q[i] <= advance(mode_q, exp_q[i]);
      end
      err_q <= sum_d[16] ? 16'hFFFF : sum_d[15:0];
    end
  end

  assign err_count = err_q;
`else
  logic unused_back;
  assign unused_back = ^{bus.data_back, bus.valid_back};
  assign err_count   = '0;
`endif

endmodule

// File: tb/tb_stim_gen_tx.sv
// Directed bench for stim_gen_tx: fixed/counter/LFSR bursts, gaps, stop,
// async reset and the loopback checker (expectations follow the macro).
module tb_stim_gen_tx;
  localparam int N_CH = 4;
  localparam int DATA_W = 8;
`ifdef STIM_GEN_TX_CHECKER_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic        clk_f = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        start_z = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [3:0]  ch_en = 4'hF;
  logic [7:0]  n_bursts = 8'd1;
  logic        busy, done, busy_z, done_z;
  logic [15:0] err_count, err_z;

  stim_gen_tx_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();
  stim_gen_tx_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus_z ();

  stim_gen_tx u_dut (
    .clk_f(clk_f), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .ch_en(ch_en), .n_bursts(n_bursts), .bus(bus.master), .busy(busy),
    .done(done), .err_count(err_count)
  );

  stim_gen_tx #(.SEED(8'h00)) u_dut_z (
    .clk_f(clk_f), .reset(reset), .start(start_z), .stop(stop), .mode(mode),
    .ch_en(ch_en), .n_bursts(n_bursts), .bus(bus_z.master), .busy(busy_z),
    .done(done_z), .err_count(err_z)
  );

  always #5 clk_f = ~clk_f;

  // Three-stage loopback; inv corrupts lane 2 of the beat captured at that edge.
  logic [31:0] d0 = '0, d1 = '0, d2 = '0;
  logic [3:0]  v0 = '0, v1 = '0, v2 = '0;
  logic        inv = 1'b0;
  always @(posedge clk_f) begin
    d0 <= bus.data_out ^ (inv ? 32'h00FF_0000 : 32'h0);
    v0 <= bus.valid_out;
    d1 <= d0; v1 <= v0;
    d2 <= d1; v2 <= v1;
  end
  assign bus.data_back    = d2;
  assign bus.valid_back   = v2;
  assign bus_z.data_back  = '0;
  assign bus_z.valid_back = '0;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_f);
    #1;
  endtask

  logic [7:0] cnt_l0 [10] = '{8'hCC, 8'hCD, 8'hCE, 8'hCF, 8'hCF, 8'hCF, 8'hD0, 8'hD1, 8'hD2, 8'hD3};
  logic [3:0] cnt_v  [10] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF};
  logic [7:0] lfsr_cc [4] = '{8'hCC, 8'h66, 8'h33, 8'hA1};
  logic [7:0] lfsr_z  [4] = '{8'h01, 8'hB8, 8'h5C, 8'h2E};

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats, cyc, dones;
    bit found;

    // reset state
    #2;
    check_val("rst_data", bus.data_out, 32'h0);
    check_val("rst_valid", {28'h0, bus.valid_out}, 32'h0);
    check_val("rst_busy", {31'h0, busy}, 32'h0);
    check_val("rst_done", {31'h0, done}, 32'h0);
    check_val("rst_err", {16'h0, err_count}, 32'h0);
    #10 reset = 1'b1;
    tick();

    // fixed mode, one burst
    mode = 2'b00; ch_en = 4'hF; n_bursts = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check_val($sformatf("fix_data%0d", j), bus.data_out, 32'hCFCE_CDCC);
      check_val($sformatf("fix_valid%0d", j), {28'h0, bus.valid_out}, 32'hF);
      check_val($sformatf("fix_busy%0d", j), {30'h0, busy, done}, 32'h2);
      tick();
    end
    check_val("fix_done", {27'h0, bus.valid_out, done}, 32'h1);
    check_val("fix_busy_end", {31'h0, busy}, 32'h0);
    tick();
    check_val("fix_done_off", {30'h0, busy, done}, 32'h0);
    repeat (4) tick();
    check_val("fix_err_clean", {16'h0, err_count}, 32'h0);

    // counter mode, two bursts with gap
    mode = 2'b01; n_bursts = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 10; t++) begin
      check_val($sformatf("cnt_l0_%0d", t), {24'h0, bus.data_out[7:0]}, {24'h0, cnt_l0[t]});
      check_val($sformatf("cnt_v_%0d", t), {28'h0, bus.valid_out}, {28'h0, cnt_v[t]});
      if (t == 5) check_val("cnt_gap_hold", bus.data_out, 32'hD2D1_D0CF);
      if (t == 9) check_val("cnt_last", bus.data_out, 32'hD6D5_D4D3);
      tick();
    end
    check_val("cnt_done", {31'h0, done}, 32'h1);
    tick();
    check_val("cnt_idle", {30'h0, busy, done}, 32'h0);

    // LFSR mode on both instances
    mode = 2'b10; n_bursts = 8'd1; ch_en = 4'h1; start = 1'b1; start_z = 1'b1;
    tick();
    start = 1'b0; start_z = 1'b0;
    check_val("lfsrz_word0", bus_z.data_out, 32'h0403_0201);
    for (int j = 0; j < 4; j++) begin
      check_val($sformatf("lfsr_cc%0d", j), {24'h0, bus.data_out[7:0]}, {24'h0, lfsr_cc[j]});
      check_val($sformatf("lfsr_z%0d", j), {24'h0, bus_z.data_out[7:0]}, {24'h0, lfsr_z[j]});
      check_val($sformatf("lfsr_v%0d", j), {24'h0, bus_z.valid_out, bus.valid_out}, 32'h11);
      tick();
    end
    check_val("lfsr_done", {30'h0, done_z, done}, 32'h3);
    tick();
    ch_en = 4'hF;

    // async reset mid-burst
    mode = 2'b00; n_bursts = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    check_val("arst_data", bus.data_out, 32'h0);
    check_val("arst_valid", {28'h0, bus.valid_out}, 32'h0);
    check_val("arst_busy_done", {30'h0, busy, done}, 32'h0);
    check_val("arst_err", {16'h0, err_count}, 32'h0);
    tick();
    #2 reset = 1'b1;
    tick();
    check_val("arst_idle", {27'h0, bus.valid_out, busy}, 32'h0);

    // stop in IDLE ignored, start beats stop
    stop = 1'b1;
    tick();
    check_val("stop_idle", {31'h0, busy}, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("start_wins", {27'h0, bus.valid_out, busy}, 32'h1F);
    check_val("start_wins_data", bus.data_out, 32'hCFCE_CDCC);
    tick();
    check_val("stop_burst", {26'h0, bus.valid_out, busy, done}, 32'h1);
    stop = 1'b0;
    tick();
    check_val("stop_done_off", {31'h0, done}, 32'h0);

    // endless run stopped after two beats of burst three
    n_bursts = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    beats = 0; cyc = 0; dones = 0; found = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (bus.valid_out != 4'h0) beats++;
      if (done) dones++;
      if (beats == 10) begin
        found = 1'b1;
        break;
      end
      tick();
      cyc++;
    end
    check_val("run_found", {31'h0, found}, 32'h1);
    check_val("run_cycles", cyc, 32'd13);
    check_val("run_no_early_done", dones, 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_val("run_stop", {26'h0, bus.valid_out, busy, done}, 32'h1);
    tick();
    check_val("run_done_once", {30'h0, busy, done}, 32'h0);
    repeat (5) tick();

    // loopback checker with one corrupted lane-beat
    mode = 2'b01; n_bursts = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    inv = 1'b1;
    tick();
    inv = 1'b0;
    tick();
    tick();
    check_val("chk_err_pre", {16'h0, err_count}, 32'h0);
    tick();
    check_val("chk_err_hit", {16'h0, err_count}, EXP_ERR);
    repeat (6) tick();
    check_val("chk_err_final", {16'h0, err_count}, EXP_ERR);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("chk_err_clear", {16'h0, err_count}, 32'h0);
    repeat (10) tick();
    check_val("chk_err_clean", {16'h0, err_count}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stim_gen_tx.md
# stim_gen_tx

Parametrised, synthesizable stimulus generator for the phy_tx datapath. It drives N_CH parallel data lanes with per-lane valids in bursts separated by idle gaps, using fixed, counter or LFSR patterns. An optional checker regenerates the same sequence and counts mismatches on the data looped back from the receiver. It sits in front of phy_tx and replaces hand-written per-test stimulus.

## Interface

- N_CH, 4, number of lanes
- DATA_W, 8, lane width in bits
- BURST_LEN, 4, beats per burst (≥1)
- GAP_LEN, 2, idle cycles between bursts (0 allowed)
- SEED, 'hCC, initial pattern base (DATA_W bits)
- LFSR_TAPS, 'hB8, Galois LFSR feedback mask (DATA_W bits)

Ports:

- clk_f  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low; low forces every register to its reset value immediately
- start  in  1  level, sampled in IDLE only
- stop  in  1  level, sampled in BURST/GAP
- mode  in  2  00 fixed, 01 counter, 10 LFSR, 11 treated as fixed
- ch_en  in  N_CH  per-lane enable
- n_bursts  in  8  bursts to send; 0 = run until stop
- data_out  out  N_CH*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
- valid_out  out  N_CH  per-lane valid
- busy  out  1  high in BURST/GAP
- done  out  1  one-cycle pulse at end of run
- data_back  in  N_CH*DATA_W  looped-back data (checker)
- valid_back  in  N_CH  looped-back valids (checker)
- err_count  out  16  saturating mismatch count

## Operation

- FSM states: IDLE, BURST, GAP, DONE. Reset value is IDLE, with every output at 0.
- IDLE: valid_out=0. When start=1 at an edge:
  - latch mode, ch_en and n_bursts;
  - base←SEED; in LFSR mode a SEED of 0 loads 1 to avoid lock-up;
  - beat and burst counters←0; err_count←0;
  - go to BURST.
- BURST: each cycle, valid_out=latched ch_en and lane i data = base+i mod 2^DATA_W.
  - base advances after each beat: fixed holds; counter +1 (wraps); LFSR next = (base>>1) ^ (base[0] ? LFSR_TAPS : 0).
  - After BURST_LEN beats, increment the burst counter. If it equals a nonzero n_bursts, go to DONE. Otherwise go to GAP, or straight to BURST if GAP_LEN=0.
- GAP: valid_out=0, data_out holds the last beat, base frozen. After GAP_LEN cycles, go to BURST.
- stop=1 in BURST or GAP: at that edge valid_out←0 and the state goes to DONE. A burst in progress is truncated.
- DONE: done=1 for one cycle, then go to IDLE.
- start while busy is ignored. stop in IDLE is ignored. If start and stop are both high in IDLE, start wins.
- Reset asserted mid-run aborts the run. The FSM is in IDLE with all outputs at 0 at release.

## Timing

- start sampled at edge k gives the first beat visible after edge k; beat j is visible after edge k+j.
- One burst occupies BURST_LEN cycles and one gap GAP_LEN cycles.
- Final beat at edge e: done is high after edge e+1 and the FSM is in IDLE after edge e+2.
- All outputs are registered; there is no combinational path from any input to any output.
- Checker latency: err_count updates on the edge that samples the mismatching valid_back/data_back.

## Configuration

- Macro: STIM_GEN_TX_CHECKER_EN.
- Defined:
  - Each lane has its own expected-value generator, loaded at start with SEED+i (LFSR: base from the adjusted seed) and advanced using the mode rules.
  - The lane's expected value advances on every cycle its valid_back[i]=1, independent of the transmit timing.
  - If data_back lane differs from expected, err_count increments, saturating at 16'hFFFF. When several lanes mismatch in one cycle, err_count adds the number of mismatching lanes.
- Undefined: data_back and valid_back are ignored and err_count is held at 0.

## Test plan

1. Drive reset=0 mid-burst -> data_out, valid_out, busy, done and err_count are 0 immediately; the FSM is in IDLE at release.
2. Fixed mode, SEED=CC, n_bursts=1, ch_en=4'b1111 -> 4 beats with lanes 0..3 = CC,CD,CE,CF each beat; done pulses one cycle after the last beat.
3. Counter mode, n_bursts=2, GAP_LEN=2 -> lane 0 = CC,CD,CE,CF, then 2 cycles valid=0 with data held at CF, then D0,D1,D2,D3, then done.
4. LFSR mode, SEED=0, ch_en=4'b0001 -> lane 0 = 01,B8,5C,2E; valid_out=4'b0001 on all beats.
5. n_bursts=0 and stop raised after 2 beats of burst 3 -> valid_out is 0 at the next edge; done pulses once; total beats = 10.
6. With STIM_GEN_TX_CHECKER_EN defined, data_out/valid_out looped to data_back/valid_back through 3 delay cycles, with lane 2 beat 1 inverted -> err_count=1. A second start clears it to 0.
